// File: rtl/mac_fcsr_unit.sv
// RISC-V fcsr owner next to the MAC: resolves rounding modes, accrues exception
// flags, buffers MAC results in a one-entry valid/ready stage, serves fflags/frm/fcsr.
module mac_fcsr_unit #(
    parameter int unsigned          PARM_RM     = 3,
    parameter int unsigned          PARM_XLEN   = 32,
    parameter logic [PARM_RM-1:0]   PARM_RM_RNE = 3'b000,
    parameter logic [PARM_RM-1:0]   PARM_RM_RTZ = 3'b001,
    parameter logic [PARM_RM-1:0]   PARM_RM_RDN = 3'b010,
    parameter logic [PARM_RM-1:0]   PARM_RM_RUP = 3'b011,
    parameter logic [PARM_RM-1:0]   PARM_RM_RMM = 3'b100,
    parameter logic [PARM_RM-1:0]   PARM_RM_DYN = 3'b111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inst_valid_i,
    input  logic [PARM_RM-1:0]   inst_rm_i,
    output logic [PARM_RM-1:0]   Rounding_mode_o,
    output logic                 rm_valid_o,
    output logic                 rm_illegal_o,
    input  logic                 mac_valid_i,
    output logic                 mac_ready_o,
    input  logic [PARM_XLEN-1:0] Result_i,
    input  logic                 NV_i,
    input  logic                 OF_i,
    input  logic                 UF_i,
    input  logic                 NX_i,
    output logic                 wb_valid_o,
    output logic [PARM_XLEN-1:0] wb_data_o,
    input  logic                 wb_ready_i,
    input  logic                 csr_valid_i,
    input  logic [1:0]           csr_op_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [PARM_XLEN-1:0] csr_wdata_i,
    output logic [PARM_XLEN-1:0] csr_rdata_o,
    output logic                 csr_rdata_valid_o,
    output logic                 csr_err_o,
    output logic [4:0]           fflags_o,
    output logic [2:0]           frm_o
);

    typedef enum logic [1:0] {
        CSR_RO = 2'b00,
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_FFLAGS = 12'h001,
        CSR_FRM    = 12'h002,
        CSR_FCSR   = 12'h003
    } csr_addr_e;

    logic [2:0]           frm_q, frm_d;
    logic [4:0]           fflags_q, fflags_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [PARM_XLEN-1:0] wb_data_q, wb_data_d;
    logic [PARM_RM-1:0]   rm_q, rm_d;
    logic                 rm_valid_q, rm_valid_d;
    logic                 rm_illegal_q, rm_illegal_d;
    logic [PARM_XLEN-1:0] csr_rdata_q, csr_rdata_d;
    logic                 csr_rdata_valid_q, csr_rdata_valid_d;
    logic                 csr_err_q, csr_err_d;

    logic                 accept;
    logic [4:0]           mac_flags;
    logic [4:0]           fflags_base;
    logic                 csr_known;
    logic [7:0]           csr_old;
    logic [7:0]           csr_new;
    logic [7:0]           wdata8;
    logic [PARM_RM-1:0]   frm_rm;
    logic                 unused_wdata;

    assign unused_wdata = ^csr_wdata_i[PARM_XLEN-1:8];
    assign wdata8       = csr_wdata_i[7:0];
    assign frm_rm       = PARM_RM'(frm_q);
    assign mac_ready_o  = !wb_valid_q || wb_ready_i;
    assign accept       = mac_valid_i && mac_ready_o;
    assign mac_flags    = {NV_i, 1'b0, OF_i, UF_i, NX_i};

    // Rounding-mode resolve; DYN reads frm_q, i.e. the value before any same-cycle CSR write.
    always_comb begin
        rm_d         = rm_q;
        rm_illegal_d = rm_illegal_q;
        rm_valid_d   = inst_valid_i;
        if (inst_valid_i) begin
            rm_d         = PARM_RM_RNE;
            rm_illegal_d = 1'b0;
            case (inst_rm_i)
                PARM_RM_RNE, PARM_RM_RTZ, PARM_RM_RDN,
                PARM_RM_RUP, PARM_RM_RMM: rm_d = inst_rm_i;
                PARM_RM_DYN: begin
                    case (frm_rm)
                        PARM_RM_RNE, PARM_RM_RTZ, PARM_RM_RDN,
                        PARM_RM_RUP, PARM_RM_RMM: rm_d = frm_rm;
                        default: rm_illegal_d = 1'b1;
                    endcase
                end
                default: rm_illegal_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        csr_known = 1'b1;
        csr_old   = '0;
        case (csr_addr_i)
            CSR_FFLAGS: csr_old = {3'b000, fflags_q};
            CSR_FRM:    csr_old = {5'b00000, frm_q};
            CSR_FCSR:   csr_old = {frm_q, fflags_q};
            default:    csr_known = 1'b0;
        endcase

        case (csr_op_i)
            CSR_RW:  csr_new = wdata8;
            CSR_RS:  csr_new = csr_old | wdata8;
            CSR_RC:  csr_new = csr_old & ~wdata8;
            default: csr_new = csr_old;
        endcase

        frm_d       = frm_q;
        fflags_base = fflags_q;
        if (csr_valid_i && csr_known && (csr_op_i != CSR_RO)) begin
            case (csr_addr_i)
                CSR_FFLAGS: fflags_base = csr_new[4:0];
                CSR_FRM:    frm_d       = csr_new[2:0];
                default: begin
                    frm_d       = csr_new[7:5];
                    fflags_base = csr_new[4:0];
                end
            endcase
        end
        // MAC flags OR on top of the CSR-written value so a colliding accrual survives.
        fflags_d = fflags_base | (accept ? mac_flags : 5'b00000);

        csr_rdata_valid_d = csr_valid_i;
        csr_err_d         = csr_valid_i && !csr_known;
        csr_rdata_d       = '0;
        if (csr_valid_i && csr_known) begin
            csr_rdata_d = PARM_XLEN'(csr_old);
        end
    end

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        if (accept) begin
            wb_valid_d = 1'b1;
            wb_data_d  = Result_i;
        end else if (wb_valid_q && wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q             <= '0;
            fflags_q          <= '0;
            wb_valid_q        <= 1'b0;
            wb_data_q         <= '0;
            rm_q              <= '0;
            rm_valid_q        <= 1'b0;
            rm_illegal_q      <= 1'b0;
            csr_rdata_q       <= '0;
            csr_rdata_valid_q <= 1'b0;
            csr_err_q         <= 1'b0;
        end else begin
            frm_q             <= frm_d;
            fflags_q          <= fflags_d;
            wb_valid_q        <= wb_valid_d;
            wb_data_q         <= wb_data_d;
            rm_q              <= rm_d;
            rm_valid_q        <= rm_valid_d;
            rm_illegal_q      <= rm_illegal_d;
            csr_rdata_q       <= csr_rdata_d;
            csr_rdata_valid_q <= csr_rdata_valid_d;
            csr_err_q         <= csr_err_d;
        end
    end

    assign frm_o             = frm_q;
    assign fflags_o          = fflags_q;
    assign wb_valid_o        = wb_valid_q;
    assign wb_data_o         = wb_data_q;
    assign Rounding_mode_o   = rm_q;
    assign rm_valid_o        = rm_valid_q;
    assign rm_illegal_o      = rm_illegal_q;
    assign csr_rdata_o       = csr_rdata_q;
    assign csr_rdata_valid_o = csr_rdata_valid_q;
    assign csr_err_o         = csr_err_q;

endmodule

// File: tb/tb_mac_fcsr_unit.sv
// Directed bench for mac_fcsr_unit: rm resolve, flag accrual, backpressure,
// CSR ops, CSR/MAC collision and asynchronous reset.
module tb_mac_fcsr_unit;

    logic        clk;
    logic        rst_n;
    logic        inst_valid_i;
    logic [2:0]  inst_rm_i;
    logic [2:0]  Rounding_mode_o;
    logic        rm_valid_o;
    logic        rm_illegal_o;
    logic        mac_valid_i;
    logic        mac_ready_o;
    logic [31:0] Result_i;
    logic        NV_i, OF_i, UF_i, NX_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic        wb_ready_i;
    logic        csr_valid_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_rdata_valid_o;
    logic        csr_err_o;
    logic [4:0]  fflags_o;
    logic [2:0]  frm_o;

    int checks   = 0;
    int failures = 0;

    mac_fcsr_unit #(.PARM_RM(3), .PARM_XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_rm_i(inst_rm_i),
        .Rounding_mode_o(Rounding_mode_o), .rm_valid_o(rm_valid_o), .rm_illegal_o(rm_illegal_o),
        .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .Result_i(Result_i),
        .NV_i(NV_i), .OF_i(OF_i), .UF_i(UF_i), .NX_i(NX_i),
        .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready_i),
        .csr_valid_i(csr_valid_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .csr_rdata_valid_o(csr_rdata_valid_o), .csr_err_o(csr_err_o),
        .fflags_o(fflags_o), .frm_o(frm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_valid_i = 1'b1;
        csr_op_i    = op;
        csr_addr_i  = addr;
        csr_wdata_i = wd;
    endtask

    task automatic mac(input logic [31:0] res, input logic [3:0] nv_of_uf_nx);
        mac_valid_i = 1'b1;
        Result_i    = res;
        {NV_i, OF_i, UF_i, NX_i} = nv_of_uf_nx;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_fflags"}, 32'(fflags_o), 32'h0);
        chk({pfx, "_frm"}, 32'(frm_o), 32'h0);
        chk({pfx, "_wb_valid"}, 32'(wb_valid_o), 32'h0);
        chk({pfx, "_wb_data"}, wb_data_o, 32'h0);
        chk({pfx, "_rm"}, 32'(Rounding_mode_o), 32'h0);
        chk({pfx, "_rm_valid"}, 32'(rm_valid_o), 32'h0);
        chk({pfx, "_rm_illegal"}, 32'(rm_illegal_o), 32'h0);
        chk({pfx, "_csr_rdata"}, csr_rdata_o, 32'h0);
        chk({pfx, "_csr_rvalid"}, 32'(csr_rdata_valid_o), 32'h0);
        chk({pfx, "_csr_err"}, 32'(csr_err_o), 32'h0);
        chk({pfx, "_mac_ready"}, 32'(mac_ready_o), 32'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        inst_valid_i = 1'b0; inst_rm_i = 3'b000;
        mac_valid_i = 1'b0; Result_i = '0;
        NV_i = 1'b0; OF_i = 1'b0; UF_i = 1'b0; NX_i = 1'b0;
        wb_ready_i = 1'b1;
        csr_valid_i = 1'b0; csr_op_i = 2'b00; csr_addr_i = '0; csr_wdata_i = '0;
        #2;
        chk_reset_state("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // DYN with frm=000 after reset
        inst_valid_i = 1'b1; inst_rm_i = 3'b111;
        tick();
        chk("dyn0_valid", 32'(rm_valid_o), 32'h1);
        chk("dyn0_rm", 32'(Rounding_mode_o), 32'h0);
        chk("dyn0_illegal", 32'(rm_illegal_o), 32'h0);
        inst_valid_i = 1'b0;

        // RW frm = 3, old value 0
        csr(2'b01, 12'h002, 32'h3);
        tick();
        chk("frm_rw_frm", 32'(frm_o), 32'h3);
        chk("frm_rw_rvalid", 32'(csr_rdata_valid_o), 32'h1);
        chk("frm_rw_rdata", csr_rdata_o, 32'h0);
        chk("rm_valid_drop", 32'(rm_valid_o), 32'h0);
        csr_valid_i = 1'b0;

        inst_valid_i = 1'b1; inst_rm_i = 3'b111;
        tick();
        chk("dyn3_rm", 32'(Rounding_mode_o), 32'h3);
        chk("dyn3_illegal", 32'(rm_illegal_o), 32'h0);
        chk("csr_rvalid_pulse", 32'(csr_rdata_valid_o), 32'h0);

        inst_rm_i = 3'b101;
        tick();
        chk("rm101_rm", 32'(Rounding_mode_o), 32'h0);
        chk("rm101_illegal", 32'(rm_illegal_o), 32'h1);

        inst_rm_i = 3'b010;
        tick();
        chk("rm010_rm", 32'(Rounding_mode_o), 32'h2);
        chk("rm010_illegal", 32'(rm_illegal_o), 32'h0);
        inst_valid_i = 1'b0;

        csr(2'b01, 12'h002, 32'h6);
        tick();
        chk("frm6", 32'(frm_o), 32'h6);
        // DYN resolves against frm=110 while the same cycle writes frm=011
        csr(2'b01, 12'h002, 32'h3);
        inst_valid_i = 1'b1; inst_rm_i = 3'b111;
        tick();
        chk("dyn6_illegal", 32'(rm_illegal_o), 32'h1);
        chk("dyn6_rm", 32'(Rounding_mode_o), 32'h0);
        chk("dyn6_frm_after", 32'(frm_o), 32'h3);
        csr_valid_i = 1'b0; inst_valid_i = 1'b0;

        // Accrual
        mac(32'h12345678, 4'b1000);
        tick();
        chk("acc1_fflags", 32'(fflags_o), 32'h10);
        chk("acc1_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("acc1_wb_data", wb_data_o, 32'h12345678);
        mac(32'h000000A5, 4'b0001);
        tick();
        chk("acc2_fflags", 32'(fflags_o), 32'h11);
        chk("acc2_wb_data", wb_data_o, 32'h000000A5);
        mac_valid_i = 1'b0; NX_i = 1'b0;
        tick();
        chk("drain_wb_valid", 32'(wb_valid_o), 32'h0);

        csr(2'b00, 12'h001, 32'h1F);
        tick();
        chk("rd_fflags", csr_rdata_o, 32'h11);
        chk("rd_fflags_keep", 32'(fflags_o), 32'h11);
        csr_valid_i = 1'b0;

        // Backpressure
        wb_ready_i = 1'b0;
        mac(32'h3F800000, 4'b0000);
        tick();
        chk("bp_wb_data", wb_data_o, 32'h3F800000);
        chk("bp_ready", 32'(mac_ready_o), 32'h0);
        mac(32'hDEADBEEF, 4'b0100);
        tick();
        chk("bp_hold_data", wb_data_o, 32'h3F800000);
        chk("bp_no_accrue", 32'(fflags_o), 32'h11);
        wb_ready_i = 1'b1;
        mac(32'h40000000, 4'b0000);
        #1;
        chk("bp_ready_again", 32'(mac_ready_o), 32'h1);
        tick();
        chk("bp_replace_data", wb_data_o, 32'h40000000);
        chk("bp_replace_valid", 32'(wb_valid_o), 32'h1);
        mac_valid_i = 1'b0;
        tick();
        chk("bp_drain", 32'(wb_valid_o), 32'h0);

        // CSR ops
        csr(2'b01, 12'h003, 32'hFF);
        tick();
        chk("fcsr_rw_old", csr_rdata_o, 32'h71);
        chk("fcsr_rw_frm", 32'(frm_o), 32'h7);
        chk("fcsr_rw_fflags", 32'(fflags_o), 32'h1F);
        chk("fcsr_rw_err", 32'(csr_err_o), 32'h0);
        csr(2'b11, 12'h001, 32'h03);
        tick();
        chk("rc_old", csr_rdata_o, 32'h1F);
        chk("rc_fflags", 32'(fflags_o), 32'h1C);
        csr(2'b10, 12'h002, 32'h1);
        tick();
        chk("rs_old", csr_rdata_o, 32'h7);
        chk("rs_frm", 32'(frm_o), 32'h7);
        csr(2'b01, 12'h7C0, 32'h0);
        tick();
        chk("bad_err", 32'(csr_err_o), 32'h1);
        chk("bad_rdata", csr_rdata_o, 32'h0);
        chk("bad_rvalid", 32'(csr_rdata_valid_o), 32'h1);
        chk("bad_frm", 32'(frm_o), 32'h7);
        chk("bad_fflags", 32'(fflags_o), 32'h1C);

        // Collision: RC all flags + accept with OF
        csr(2'b11, 12'h001, 32'h1F);
        mac(32'hCAFEF00D, 4'b0100);
        tick();
        chk("coll_fflags", 32'(fflags_o), 32'h04);
        chk("coll_old", csr_rdata_o, 32'h1C);
        chk("coll_wb_data", wb_data_o, 32'hCAFEF00D);
        csr_valid_i = 1'b0; mac_valid_i = 1'b0; OF_i = 1'b0;
        wb_ready_i = 1'b0;
        inst_valid_i = 1'b1; inst_rm_i = 3'b001;
        tick();
        chk("pre_rst_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("pre_rst_rm_valid", 32'(rm_valid_o), 32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("arst");
        inst_valid_i = 1'b0;
        wb_ready_i = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_fcsr_unit.md
# mac_fcsr_unit

Floating-point control/status unit on the far side of the MAC operand/result interface: receives `Result`/`NV`/`OF`/`UF`/`NX` from the MAC and resolves the rounding mode the MAC consumes. Owns `frm` and accrued `fflags` (RISC-V `fcsr`) and buffers each MAC result in a one-entry writeback register with valid/ready. It also serves CSR accesses to `fflags`, `frm` and `fcsr`, and flags illegal rounding modes.

## Interface
- `PARM_RM`, 3, rounding-mode width
- `PARM_XLEN`, 32, data width
- `PARM_RM_RNE`/`RTZ`/`RDN`/`RUP`/`RMM`, 3'b000/001/010/011/100, static rounding-mode encodings; 3'b111 = dynamic (DYN)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `inst_valid_i`  in  1  instruction rm field presented
- `inst_rm_i`  in  `PARM_RM`  instruction rm field
- `Rounding_mode_o`  out  `PARM_RM`  resolved mode to MAC
- `rm_valid_o`  out  1  `Rounding_mode_o` / `rm_illegal_o` valid
- `rm_illegal_o`  out  1  illegal rounding mode
- `mac_valid_i`  in  1  MAC result valid
- `mac_ready_o`  out  1  unit can accept result
- `Result_i`  in  `PARM_XLEN`  MAC result
- `NV_i`, `OF_i`, `UF_i`, `NX_i`  in  1 each  MAC exception flags
- `wb_valid_o`  out  1  writeback entry valid
- `wb_data_o`  out  `PARM_XLEN`  buffered result
- `wb_ready_i`  in  1  consumer accepts entry
- `csr_valid_i`  in  1  CSR access request
- `csr_op_i`  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 read-only
- `csr_addr_i`  in  12  0x001 `fflags`, 0x002 `frm`, 0x003 `fcsr`
- `csr_wdata_i`  in  `PARM_XLEN`  CSR write operand
- `csr_rdata_o`  out  `PARM_XLEN`  old CSR value
- `csr_rdata_valid_o`  out  1  `csr_rdata_o` valid
- `csr_err_o`  out  1  unknown CSR address
- `fflags_o`  out  5  `{NV,DZ,OF,UF,NX}`
- `frm_o`  out  3  current `frm`

## Operation
- State: `frm[2:0]`; `fflags[4:0]` (bit 4 NV, 3 DZ, 2 OF, 1 UF, 0 NX); writeback register (valid + data); registered rm outputs; registered CSR response.
- **Rounding-mode resolve**, on `inst_valid_i`:
  - `inst_rm_i` 000–100 → passed through.
  - 111 → current `frm`.
  - 101/110, or DYN with `frm` in 101–111 → `Rounding_mode_o`=RNE, `rm_illegal_o`=1.
- **MAC accept**: `mac_ready_o` = !`wb_valid_o` || `wb_ready_i`; accept = `mac_valid_i` && `mac_ready_o`.
  - On accept: `wb_data_o` ← `Result_i`, `wb_valid_o` ← 1, `fflags` |= `{NV_i,0,OF_i,UF_i,NX_i}`.
  - Flags are never accrued without accept.
  - DZ is changed only by CSR writes.
- **Writeback**: `wb_valid_o` clears when `wb_valid_o` && `wb_ready_i` with no accept the same cycle. Accept plus drain in the same cycle keeps valid=1 with the new data (full-throughput pipeline).
- **CSR read value**: `fflags` → `{27'b0,fflags}`; `frm` → `{29'b0,frm}`; `fcsr` → `{24'b0,frm,fflags}`.
- **CSR write value** (op 01/10/11): new = wdata / old|wdata / old&~wdata, masked to the field width.
  - `fcsr` writes `frm`←bits[7:5] and `fflags`←bits[4:0].
  - `frm` stores any 3-bit value, including 101–111; illegality is detected only at use.
  - Op 00 writes nothing.
- **Unknown address**: no state change, `csr_rdata_o`=0, `csr_err_o`=1.
- **Same-cycle CSR write and MAC accept**: `fflags` = CSR-written value | MAC flags. The accrual is never lost.
- **Same-cycle CSR write to `frm` and DYN resolve**: the resolve uses the pre-write `frm`.

## Timing
- All outputs are registered; `fflags_o`/`frm_o` are direct register outputs.
- Reset values: `fflags`=0, `frm`=000, `wb_valid_o`=0, `wb_data_o`=0, `Rounding_mode_o`=000, `rm_valid_o`=0, `rm_illegal_o`=0, `csr_rdata_o`=0, `csr_rdata_valid_o`=0, `csr_err_o`=0.
- `mac_ready_o` is combinational from `wb_valid_o` and `wb_ready_i`, and is 1 in reset.
- rm resolve latency 1: `rm_valid_o`, `Rounding_mode_o` and `rm_illegal_o` are updated the cycle after `inst_valid_i`. `rm_valid_o` deasserts when `inst_valid_i` was low.
- CSR latency 1: `csr_rdata_valid_o`, `csr_rdata_o` and `csr_err_o` pulse the cycle after `csr_valid_i`. The written value is visible on `fflags_o`/`frm_o` in that same cycle.
- Flag accrual is visible on `fflags_o` the cycle after accept.
- Writeback holds `wb_data_o` stable while `wb_valid_o` && !`wb_ready_i`.
- Reset asserted mid-operation: all state clears immediately; a pending writeback entry is discarded.

## Test plan
- **Reset/rm resolve**: after reset, `inst_rm_i`=111 → `Rounding_mode_o`=000, illegal=0. Write `frm`=011, then DYN → 011. `inst_rm_i`=101 → RNE, illegal=1. `frm`=110 + DYN → illegal=1.
- **Accrue**: accept with `NV_i`=1, then a second accept with `NX_i`=1 → `fflags_o`=5'b10001. A `fflags` read returns 0x11.
- **Backpressure**: `wb_ready_i`=0, accept `Result_i`=0x3F800000 → a second `mac_valid_i` sees `mac_ready_o`=0 and its flags are not accrued. `wb_ready_i`=1 with a new valid → data replaced, `wb_valid_o` stays 1.
- **CSR ops**: RW `fcsr`=0xFF → `frm`=111, `fflags`=1F. RC `fflags` 0x03 → 1C, returns old 0x1F. RS `frm` 0x1 → unchanged 111. Address 0x7C0 → `csr_err_o`=1, state unchanged.
- **Collision**: RC `fflags` 0x1F in the same cycle as an accept with `OF_i`=1 → `fflags_o`=5'b00100.
- **Async reset**: assert `rst_n` mid-transfer with `wb_valid_o`=1 → all outputs return to reset values before the next edge.
